// File: rtl/decrypt_unit_pkg.sv
// Shared definitions for the nibble-encryption datapath: default widths,
// controller state encodings and the rotate amount used by both directions.
package decrypt_unit_pkg;

    localparam int NW_DEF = 4;
    localparam int KW_DEF = 4;
    localparam int CW_DEF = 8;

    localparam int ROT_N = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_ROT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/decrypt_unit_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module div_step
    import decrypt_unit_pkg::*;
#(
    parameter int KW = KW_DEF
) (
    input  logic [KW:0]   rem_in,
    input  logic          dbit,
    input  logic [KW-1:0] key,
    output logic [KW:0]   rem_out,
    output logic          qbit
);

    logic [KW:0] shifted;

    assign shifted = {rem_in[KW-1:0], dbit};

    // A bit shifted out of the top means the true value exceeds any KW-bit key.
    always_comb begin
        qbit    = rem_in[KW] | (shifted >= {1'b0, key});
        rem_out = qbit ? (shifted - {1'b0, key}) : shifted;
    end

endmodule

// File: rtl/decrypt_unit.sv
// Recovers a plaintext nibble from a stored ciphertext: restoring divide by the
// key (one bit per clock) followed by undoing the double right-rotate.
module decrypt_unit
    import decrypt_unit_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int KW = KW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] cipher,
    input  logic [KW-1:0] key,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] num_out,
    output logic          err
);

    localparam int SW = $clog2(CW);
    localparam logic [SW-1:0] LAST_STEP = SW'(CW - 1);

    state_t        state;
    logic [SW-1:0] cnt;
    logic [CW-1:0] dvd;
    logic [KW-1:0] dvs;
    logic [KW:0]   rem;
    logic [KW:0]   rem_nx;
    logic          qbit;
    logic          q_bad;

    function automatic logic [NW-1:0] unrotate(input logic [NW-1:0] q);
        return (q << ROT_N) | (q >> (NW - ROT_N));
    endfunction

    div_step #(.KW(KW)) u_step (
        .rem_in  (rem),
        .dbit    (dvd[CW-1]),
        .key     (dvs),
        .rem_out (rem_nx),
        .qbit    (qbit)
    );

    // After the last step dvd holds the full quotient.
    assign q_bad = (|dvd[CW-1:NW]) | (|rem);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            num_out <= '0;
            err     <= 1'b0;
            cnt     <= '0;
            dvd     <= '0;
            dvs     <= '0;
            rem     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dvd <= cipher;
                        dvs <= key;
                        rem <= '0;
                        cnt <= '0;
                        if (key == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_DIV;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_DIV: begin
                    dvd <= {dvd[CW-2:0], qbit};
                    rem <= rem_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP)
                        state <= ST_ROT;
                end
                ST_ROT: begin
                    err     <= q_bad;
                    num_out <= q_bad ? '0 : unrotate(dvd[NW-1:0]);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    // Entering DONE without a pulse only happens on the zero-key path.
                    if (!done) begin
                        done    <= 1'b1;
                        err     <= 1'b1;
                        num_out <= '0;
                    end else begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decrypt_unit.sv
// Directed bench for decrypt_unit: hand-computed quotients, latency, error
// cases, ignored starts, asynchronous abort and back-to-back operation.
module tb_decrypt_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] cipher;
    logic [3:0] key;
    logic       busy;
    logic       done;
    logic [3:0] num_out;
    logic       err;

    int checks   = 0;
    int failures = 0;

    decrypt_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .cipher  (cipher),
        .key     (key),
        .busy    (busy),
        .done    (done),
        .num_out (num_out),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Leaves the bench at the falling edge just after the accepting edge.
    task automatic launch(input logic [7:0] c, input logic [3:0] k);
        @(negedge clk);
        cipher = c;
        key    = k;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // cyc = rising edges after the accepting edge until done is seen.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cipher = '0; key = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, num_out, err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b num=%b err=%b want all 0",
                     busy, done, num_out, err);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] cv [3] = '{8'h10, 8'h30, 8'h1E};
        logic [3:0] kv [3] = '{4'h8, 4'h8, 4'hA};
        logic [3:0] nv [3] = '{4'b1000, 4'b1001, 4'b1100};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            launch(cv[i], kv[i]);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL basic_busy[%0d] got %b want 1", i, busy);
            end
            wait_done(cyc);
            checks++;
            if (cyc !== 9) begin
                failures++;
                $display("FAIL basic_latency[%0d] got %0d want 9", i, cyc);
            end
            checks++;
            if (num_out !== nv[i] || err !== 1'b0) begin
                failures++;
                $display("FAIL basic_result[%0d] got num=%b err=%b want num=%b err=0",
                         i, num_out, err, nv[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL basic_pulse[%0d] got done=%b busy=%b want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int pulses = 0;
        logic [3:0] seen_num = 4'hx;
        logic       seen_err = 1'bx;
        launch(8'hC4, 4'hE);
        cipher = 8'h10; key = 4'h8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                seen_num = num_out;
                seen_err = err;
            end
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL ignore_pulses got %0d want 1", pulses);
        end
        checks++;
        if (seen_num !== 4'b1011 || seen_err !== 1'b0) begin
            failures++;
            $display("FAIL ignore_result got num=%b err=%b want num=1011 err=0", seen_num, seen_err);
        end
    endtask

    task automatic test_errors();
        logic [7:0] cv [3] = '{8'h1F, 8'hF0, 8'h33};
        logic [3:0] kv [3] = '{4'h8, 4'h1, 4'h0};
        int         lv [3] = '{9, 9, 1};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            launch(cv[i], kv[i]);
            wait_done(cyc);
            checks++;
            if (cyc !== lv[i]) begin
                failures++;
                $display("FAIL err_latency[%0d] got %0d want %0d", i, cyc, lv[i]);
            end
            checks++;
            if (err !== 1'b1 || num_out !== 4'b0000) begin
                failures++;
                $display("FAIL err_result[%0d] got num=%b err=%b want num=0000 err=1",
                         i, num_out, err);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL err_pulse[%0d] got done=%b want 0", i, done);
            end
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        launch(8'h30, 4'h8);
        wait_done(cyc);
        launch(8'hC4, 4'hE);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || num_out !== 4'b1001) begin
            failures++;
            $display("FAIL abort_pre got busy=%b num=%b want busy=1 num=1001", busy, num_out);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, num_out, err} !== 7'b0) begin
            failures++;
            $display("FAIL abort_state got busy=%b done=%b num=%b err=%b want all 0",
                     busy, done, num_out, err);
        end
        @(negedge clk);
        rst = 1'b0;
        launch(8'h10, 4'h8);
        wait_done(cyc);
        checks++;
        if (cyc !== 9 || num_out !== 4'b1000 || err !== 1'b0) begin
            failures++;
            $display("FAIL abort_recover got lat=%0d num=%b err=%b want lat=9 num=1000 err=0",
                     cyc, num_out, err);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        launch(8'h1E, 4'hA);
        wait_done(cyc);
        launch(8'h30, 4'h8);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept got busy=%b want 1", busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (num_out !== 4'b1100 || err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_hold got num=%b err=%b want num=1100 err=0", num_out, err);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 6 || num_out !== 4'b1001) begin
            failures++;
            $display("FAIL b2b_result got wait=%0d num=%b want wait=6 num=1001", cyc, num_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_ignore();
        test_errors();
        test_async_reset();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
